msg_schedule: RTL

SHA-2 message-schedule generator: transmitter feeding the hash compute unit's word-input AXI-Stream port. Accepts 16 padded block words per block on a slave stream. Emits the full round-word sequence W_0..W_{N-1} on a master stream, one word per handshake:
- N = 64 for SHA-224/256.
- N = 80 for SHA-384/512.

Sits between the padder/DMA front-end and the hash compute unit.

---
 rtl/msg_schedule_pkg.sv | 67 ++++++
 rtl/msg_schedule_small_sigma.sv | 57 +++++
 rtl/msg_schedule.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/msg_schedule_pkg.sv
// ----------------------------------------------------------------------------
// msg_schedule_pkg
// Shared SHA-2 schedule constants, types and helpers.
//   - Round counts and window depth, also used by the hash compute unit's
//     round counter.
//   - Small-sigma rotate/shift amounts for the 32-bit and 64-bit modes.
//   - Mode-selectable modulo adder (2^32 or 2^64).
// Optional feature macro: MSG_SCHEDULE_SHA512_EN. When it is defined the
// schedule datapath is 64 bits wide; otherwise it is 32 bits wide.
// ----------------------------------------------------------------------------
package msg_schedule_pkg;

    localparam int ROUNDS_256   = 64;
    localparam int ROUNDS_512   = 80;
    localparam int SCHED_WINDOW = 16;

    // sigma0 / sigma1, SHA-224/256
    localparam int SIG0_32_ROT_A = 7;
    localparam int SIG0_32_ROT_B = 18;
    localparam int SIG0_32_SHR   = 3;
    localparam int SIG1_32_ROT_A = 17;
    localparam int SIG1_32_ROT_B = 19;
    localparam int SIG1_32_SHR   = 10;

    // sigma0 / sigma1, SHA-384/512
    localparam int SIG0_64_ROT_A = 1;
    localparam int SIG0_64_ROT_B = 8;
    localparam int SIG0_64_SHR   = 7;
    localparam int SIG1_64_ROT_A = 19;
    localparam int SIG1_64_ROT_B = 61;
    localparam int SIG1_64_SHR   = 6;

`ifdef MSG_SCHEDULE_SHA512_EN
    localparam int SCHED_WORD_W = 64;
`else
    localparam int SCHED_WORD_W = 32;
`endif

    typedef enum logic {
        ST_LOAD,
        ST_EXPAND
    } sched_state_t;

    typedef enum logic {
        SIGMA0,
        SIGMA1
    } sigma_sel_t;

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // In 32-bit mode the carry out of bit 31 is discarded and the upper half
    // of the result is forced to zero.
    function automatic logic [63:0] mode_add(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic        mode64);
        logic [31:0] lo;
        lo = a[31:0] + b[31:0];
        return mode64 ? (a + b) : {32'd0, lo};
    endfunction

endpackage

// File: rtl/msg_schedule_small_sigma.sv
// ----------------------------------------------------------------------------
// small_sigma
// Combinational SHA-2 small sigma (sigma0 or sigma1) for 32- or 64-bit words.
// Ports:
//   mode64 in  1       1 = SHA-384/512 sigma, 0 = SHA-224/256 sigma
//   sel    in  1       SIGMA0 or SIGMA1
//   x      in  WORD_W  operand (32-bit mode uses x[31:0])
//   y      out WORD_W  result (upper half 0 in 32-bit mode)
// With WORD_W = 32 (MSG_SCHEDULE_SHA512_EN undefined) only the 32-bit
// functions are built and mode64 has no effect.
// ----------------------------------------------------------------------------
module small_sigma
    import msg_schedule_pkg::*;
#(
    parameter int WORD_W = SCHED_WORD_W
)(
    input  logic              mode64,
    input  sigma_sel_t        sel,
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y
);

    logic [31:0] y32;

    always_comb begin
        if (sel == SIGMA0) begin
            y32 = rotr32(x[31:0], SIG0_32_ROT_A) ^ rotr32(x[31:0], SIG0_32_ROT_B)
                ^ (x[31:0] >> SIG0_32_SHR);
        end else begin
            y32 = rotr32(x[31:0], SIG1_32_ROT_A) ^ rotr32(x[31:0], SIG1_32_ROT_B)
                ^ (x[31:0] >> SIG1_32_SHR);
        end
    end

    generate
        if (WORD_W == 64) begin : g_w64
            logic [63:0] y64;

            always_comb begin
                if (sel == SIGMA0) begin
                    y64 = rotr64(x, SIG0_64_ROT_A) ^ rotr64(x, SIG0_64_ROT_B)
                        ^ (x >> SIG0_64_SHR);
                end else begin
                    y64 = rotr64(x, SIG1_64_ROT_A) ^ rotr64(x, SIG1_64_ROT_B)
                        ^ (x >> SIG1_64_SHR);
                end
            end

            assign y = mode64 ? y64 : {32'd0, y32};
        end else begin : g_w32
            logic unused_mode64;
            assign unused_mode64 = mode64;
            assign y = y32;
        end
    endgenerate

endmodule

// File: rtl/msg_schedule.sv
// ----------------------------------------------------------------------------
// msg_schedule
// SHA-2 message-schedule generator. Takes 16 block words per block on the
// slave stream and emits W_0..W_{N-1} on the master stream (N = 64 for
// SHA-224/256, N = 80 for SHA-384/512). W_0..W_15 pass straight through;
// W_16.. are expanded from a 16-word sliding window.
// Ports:
//   axi_aclk       in  1      clock
//   reset          in  1      synchronous, active-high
//   sha_type       in  2      msb selects 64-bit / 80-round mode
//   s_axis_tdata   in  S_W    block word M_j
//   s_axis_tvalid  in  1      block word valid
//   s_axis_tready  out 1      block word accepted
//   s_axis_tlast   in  1      word 15 of the final block
//   m_axis_tdata   out M_W    W_t (upper 32 bits 0 in 32-bit mode)
//   m_axis_tvalid  out 1      W_t valid
//   m_axis_tready  in  1      downstream accepts W_t
//   m_axis_tlast   out 1      W_{N-1}
//   m_axis_tuser   out 1      final-block flag, meaningful from t = 15
// Optional feature macro: MSG_SCHEDULE_SHA512_EN (adds 64-bit/80-round mode).
// Without it the datapath is 32 bits, sha_type[1] is ignored and N = 64.
// ----------------------------------------------------------------------------
module msg_schedule
    import msg_schedule_pkg::*;
#(
    parameter int S_AXIS_DATA_WIDTH = 64,
    parameter int M_AXIS_DATA_WIDTH = 64
)(
    input  logic                         axi_aclk,
    input  logic                         reset,
    input  logic [1:0]                   sha_type,
    input  logic [S_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic                         s_axis_tlast,
    output logic [M_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         m_axis_tuser
);

    localparam int W = SCHED_WORD_W;

    sched_state_t state;
    logic [6:0]   t;
    logic [6:0]   t_last;
    logic         mode64;
    logic         cur_mode;
    logic         last_blk;
    logic         load;
    logic         hs;
    logic [W-1:0] win [SCHED_WINDOW];
    logic [W-1:0] sig0;
    logic [W-1:0] sig1;
    logic [63:0]  in_word;
    logic [63:0]  exp_sum;
    logic [63:0]  out_word;
    logic         unused_inputs;

    // sha_type[0] only distinguishes truncated variants, which the schedule
    // does not care about; upper input bits are unused in the 32-bit build.
    assign unused_inputs = ^{sha_type, s_axis_tdata};

    assign load = (state == ST_LOAD);

`ifdef MSG_SCHEDULE_SHA512_EN
    // Word 0 is presented before the mode is latched, so its masking follows
    // the live sha_type; every later beat uses the latched mode.
    assign cur_mode = (load && t == 7'd0) ? sha_type[1] : mode64;
`else
    assign cur_mode = 1'b0;
    assign mode64   = 1'b0;
`endif

    assign t_last = mode64 ? 7'(ROUNDS_512 - 1) : 7'(ROUNDS_256 - 1);

    small_sigma #(.WORD_W(W)) u_sigma0 (
        .mode64 (mode64),
        .sel    (SIGMA0),
        .x      (win[1]),
        .y      (sig0)
    );

    small_sigma #(.WORD_W(W)) u_sigma1 (
        .mode64 (mode64),
        .sel    (SIGMA1),
        .x      (win[14]),
        .y      (sig1)
    );

    always_comb begin
        in_word = 64'(s_axis_tdata[W-1:0]);
        if (!cur_mode) begin
            in_word[63:32] = 32'd0;
        end
        exp_sum  = mode_add(mode_add(64'(sig1), 64'(win[9]), mode64),
                            mode_add(64'(sig0), 64'(win[0]), mode64),
                            mode64);
        out_word = load ? in_word : exp_sum;
    end

    // Handshake outputs are gated by reset so nothing moves while it is high.
    assign s_axis_tready = !reset && load && m_axis_tready;
    assign m_axis_tvalid = !reset && (load ? s_axis_tvalid : 1'b1);
    assign m_axis_tlast  = !reset && !load && (t == t_last);
    assign m_axis_tuser  = !reset && (load ? ((t == 7'(SCHED_WINDOW - 1)) && s_axis_tlast)
                                           : last_blk);
    assign m_axis_tdata  = reset ? '0 : M_AXIS_DATA_WIDTH'(out_word);

    assign hs = m_axis_tvalid && m_axis_tready;

    always_ff @(posedge axi_aclk) begin
        if (reset) begin
            state    <= ST_LOAD;
            t        <= '0;
            last_blk <= 1'b0;
`ifdef MSG_SCHEDULE_SHA512_EN
            mode64   <= 1'b0;
`endif
        end else if (hs) begin
            if (load) begin
`ifdef MSG_SCHEDULE_SHA512_EN
                if (t == 7'd0) begin
                    mode64 <= sha_type[1];
                end
`endif
                if (t == 7'(SCHED_WINDOW - 1)) begin
                    last_blk <= s_axis_tlast;
                    state    <= ST_EXPAND;
                end
                t <= t + 7'd1;
            end else if (t == t_last) begin
                state <= ST_LOAD;
                t     <= '0;
            end else begin
                t <= t + 7'd1;
            end
        end
    end

    // Window holds W_{t-16}..W_{t-1}; contents after reset are irrelevant
    // because the next block refills all 16 entries before expanding.
    always_ff @(posedge axi_aclk) begin
        if (hs) begin
            for (int i = 0; i < SCHED_WINDOW - 1; i++) begin
                win[i] <= win[i+1];
            end
            win[SCHED_WINDOW-1] <= out_word[W-1:0];
        end
    end

endmodule
